count_serializer: RTL and testbench

//  Downstream consumer of the user-project counter value. On a start pulse, snapshots the

---
 rtl/count_serializer.sv | 104 ++++++++++
 tb/tb_count_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/count_serializer.sv
// Snapshots the counter on a start pulse and shifts it out MSB-first on sclk/sdata/sframe.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module count_serializer #(
   parameter int BITS = 32,
   parameter int DIV  = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [BITS-1:0] count,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] snapshot,
   output logic            sclk,
   output logic            sdata,
   output logic            sframe,
   output logic [2:0]      ser_oeb
);

`ifdef SER_PARITY_EN
   localparam int NBITS = BITS + 1;
`else
   localparam int NBITS = BITS;
`endif
   localparam int DIV_W = $clog2(DIV + 1);
   localparam int BC_W  = $clog2(BITS + 2);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] END   = 2'd2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(NBITS - 1);

   logic [1:0]       state;
   logic [NBITS-1:0] shreg;
   logic [DIV_W-1:0] divcnt;
   logic [BC_W-1:0]  bitcnt;

   // Acceptance is allowed whenever busy is low, including the END cycle,
   // which gives the single idle cycle between back-to-back frames.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         shreg    <= '0;
         divcnt   <= '0;
         bitcnt   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         snapshot <= '0;
         sclk     <= 1'b0;
         sdata    <= 1'b0;
         sframe   <= 1'b0;
         ser_oeb  <= 3'b111;
      end else begin
         ser_oeb <= 3'b000;
         done    <= 1'b0;
         case (state)
            IDLE, END: begin
               state <= IDLE;
               if (start) begin
`ifdef SER_PARITY_EN
                  shreg <= {count, ^count};
`else
                  shreg <= count;
`endif
                  snapshot <= count;
                  sdata    <= count[BITS-1];
                  sframe   <= 1'b1;
                  busy     <= 1'b1;
                  sclk     <= 1'b0;
                  divcnt   <= '0;
                  bitcnt   <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (divcnt == DIV_LAST) begin
                  divcnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else if (bitcnt == BIT_LAST) begin
                     sclk   <= 1'b0;
                     sdata  <= 1'b0;
                     sframe <= 1'b0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= END;
                  end else begin
                     sclk   <= 1'b0;
                     shreg  <= {shreg[NBITS-2:0], 1'b0};
                     sdata  <= shreg[NBITS-2];
                     bitcnt <= bitcnt + 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_serializer.sv
// Directed bench for count_serializer: BITS=8 at DIV=2 and DIV=1, parity aware via SER_PARITY_EN.
module tb_count_serializer;

`ifdef SER_PARITY_EN
   localparam int NB = 9;
   localparam logic [15:0] EXP_A5 = 16'h014A;
   localparam logic [15:0] EXP_01 = 16'h0003;
`else
   localparam int NB = 8;
   localparam logic [15:0] EXP_A5 = 16'h00A5;
   localparam logic [15:0] EXP_01 = 16'h0001;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] count = 8'h00;
   logic       start = 1'b0;
   logic       busy, done, sclk, sdata, sframe;
   logic [7:0] snapshot;
   logic [2:0] ser_oeb;

   logic [7:0] count2 = 8'hA5;
   logic       start2 = 1'b0;
   logic       busy2, done2, sclk2, sdata2, sframe2;
   logic [7:0] snapshot2;
   logic [2:0] ser_oeb2;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   count_serializer #(.BITS(8), .DIV(2)) dut (
      .clk(clk), .reset_n(reset_n), .count(count), .start(start),
      .busy(busy), .done(done), .snapshot(snapshot), .sclk(sclk),
      .sdata(sdata), .sframe(sframe), .ser_oeb(ser_oeb)
   );

   count_serializer #(.BITS(8), .DIV(1)) dut_fast (
      .clk(clk), .reset_n(reset_n), .count(count2), .start(start2),
      .busy(busy2), .done(done2), .snapshot(snapshot2), .sclk(sclk2),
      .sdata(sdata2), .sframe(sframe2), .ser_oeb(ser_oeb2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] c);
      start = s;
      count = c;
      stepClock();
   endtask

   // Starts a frame and records bits sampled at sclk rises, sframe-high cycles and done pulses.
   task automatic captureFrame(input int restart_at, input int change_at,
                               output logic [15:0] bits, output int nbits,
                               output int frame_len, output int dones);
      logic prev_sclk;
      int   idle_after;
      prev_sclk = 1'b0;
      bits = '0;
      nbits = 0;
      frame_len = 0;
      dones = 0;
      idle_after = 0;
      start = 1'b1;
      for (int c = 0; c < 400; c++) begin
         stepClock();
         if (sframe) frame_len++;
         if (done) dones++;
         if (sclk && !prev_sclk) begin
            bits = {bits[14:0], sdata};
            nbits++;
         end
         prev_sclk = sclk;
         start = (c + 1 == restart_at);
         if (c + 1 == change_at) count = 8'h00;
         if (dones > 0 && !sframe) begin
            idle_after++;
            if (idle_after > 4) break;
         end
      end
      start = 1'b0;
   endtask

   logic [15:0] bits;
   int          nbits, frame_len, dones;
   logic        fr_hist [0:39];
   logic        dn_hist [0:39];
   int          highs, dn_total;

   initial begin
      $display("[TB] start");
      reset_n = 1'b0;
      repeat (3) applyStimulus(1'b0, 8'h00);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_sclk", sclk, 0);
      checkOutput("rst_sdata", sdata, 0);
      checkOutput("rst_sframe", sframe, 0);
      checkOutput("rst_snapshot", snapshot, 0);
      checkOutput("rst_oeb", ser_oeb, 3'b111);
      reset_n = 1'b1;
      applyStimulus(1'b0, 8'h00);
      checkOutput("oeb_release", ser_oeb, 3'b000);

      // First bit presented one cycle after the start edge
      start = 1'b1;
      count = 8'hA5;
      stepClock();
      start = 1'b0;
      checkOutput("accept_busy", busy, 1);
      checkOutput("accept_sframe", sframe, 1);
      checkOutput("accept_sdata", sdata, 1);
      checkOutput("accept_sclk", sclk, 0);
      repeat (40) stepClock();
      checkOutput("idle_busy", busy, 0);

      count = 8'hA5;
      captureFrame(0, 0, bits, nbits, frame_len, dones);
      checkOutput("a5_bits", bits, EXP_A5);
      checkOutput("a5_nbits", nbits, NB);
      checkOutput("a5_len", frame_len, NB * 4);
      checkOutput("a5_done", dones, 1);
      checkOutput("a5_snapshot", snapshot, 8'hA5);

      // Count cleared and a second start mid-frame must not disturb the frame
      count = 8'hA5;
      captureFrame(10, 6, bits, nbits, frame_len, dones);
      checkOutput("mid_bits", bits, EXP_A5);
      checkOutput("mid_len", frame_len, NB * 4);
      checkOutput("mid_done", dones, 1);
      checkOutput("mid_snapshot", snapshot, 8'hA5);
      checkOutput("mid_busy_after", busy, 0);

      count = 8'h01;
      captureFrame(0, 0, bits, nbits, frame_len, dones);
      checkOutput("01_bits", bits, EXP_01);
      checkOutput("01_len", frame_len, NB * 4);

      // Reset during bit 3 aborts without a done pulse
      start = 1'b1;
      count = 8'h3C;
      stepClock();
      start = 1'b0;
      repeat (13) stepClock();
      checkOutput("abort_busy_before", busy, 1);
      reset_n = 1'b0;
      stepClock();
      checkOutput("abort_sframe", sframe, 0);
      checkOutput("abort_sclk", sclk, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_oeb", ser_oeb, 3'b111);
      reset_n = 1'b1;
      stepClock();
      checkOutput("abort_oeb_release", ser_oeb, 3'b000);
      dn_total = 0;
      for (int i = 0; i < 40; i++) begin
         stepClock();
         if (done) dn_total++;
      end
      checkOutput("abort_no_done", dn_total, 0);
      count = 8'hA5;
      captureFrame(0, 0, bits, nbits, frame_len, dones);
      checkOutput("post_abort_bits", bits, EXP_A5);
      checkOutput("post_abort_done", dones, 1);

      // DIV=1 with start held: frames of NB*2 cycles separated by one END cycle
      start2 = 1'b1;
      highs = 0;
      dn_total = 0;
      for (int i = 0; i < 2 * (NB * 2 + 1); i++) begin
         stepClock();
         fr_hist[i] = sframe2;
         dn_hist[i] = done2;
         if (sframe2) highs++;
         if (done2) dn_total++;
      end
      start2 = 1'b0;
      checkOutput("b2b_highs", highs, NB * 4);
      checkOutput("b2b_dones", dn_total, 2);
      checkOutput("b2b_gap_sframe", fr_hist[NB * 2], 0);
      checkOutput("b2b_gap_done", dn_hist[NB * 2], 1);
      checkOutput("b2b_restart", fr_hist[NB * 2 + 1], 1);
      checkOutput("b2b_first_high", fr_hist[0], 1);
      checkOutput("b2b_snapshot", snapshot2, 8'hA5);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
